data_memory_ws: RTL and testbench

- Parametrised successor to the single-cycle data memory.
- Adds RISC-V sub-word loads and stores (byte, half and word, with sign or zero extension), little-endian byte lanes, misalignment and illegal-funct3 error reporting, and a configurable wait-state FSM with a ready handshake.
- Sits between the core's load/store path and the memory array. The core stalls until Mem_Ready is asserted.

---
 rtl/data_memory_ws_pkg.sv | 19 +
 rtl/data_memory_ws_if.sv | 25 ++
 rtl/data_memory_ws_load_store_align.sv | 74 +++++++
 rtl/data_memory_ws.sv | 149 ++++++++++++++
 tb/tb_data_memory_ws.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_ws_pkg.sv
// Shared definitions for the wait-state data memory: funct3 encodings,
// FSM state encoding and the wait counter width.
package data_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/data_memory_ws_if.sv
// Load/store request bus between the core (master) and the memory (slave).
// Request: MemRead, MemWrite, funct3, Mem_Addr, Write_Data.
// Response: Read_Data, Mem_Ready (one-cycle pulse), Mem_Err.
interface data_memory_ws_if;

    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] Mem_Addr;
    logic [31:0] Write_Data;
    logic [31:0] Read_Data;
    logic        Mem_Ready;
    logic        Mem_Err;

    modport master (
        output MemRead, MemWrite, funct3, Mem_Addr, Write_Data,
        input  Read_Data, Mem_Ready, Mem_Err
    );

    modport slave (
        input  MemRead, MemWrite, funct3, Mem_Addr, Write_Data,
        output Read_Data, Mem_Ready, Mem_Err
    );

endinterface

// File: rtl/data_memory_ws_load_store_align.sv
// Combinational RV32I sub-word alignment: byte enables and lane-shifted
// store word, extended load data, and misalignment / illegal-funct3 error.
// In: is_store, funct3, addr[1:0], write_data, read_word.
// Out: byte_en, write_word, load_data, err.
module load_store_align
    import data_mem_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] write_data,
    input  logic [31:0] read_word,
    output logic [3:0]  byte_en,
    output logic [31:0] write_word,
    output logic [31:0] load_data,
    output logic        err
);

    logic [4:0]  sh;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sh         = {addr, 3'b000};
        sel_byte   = 8'(read_word >> sh);
        sel_half   = addr[1] ? read_word[31:16] : read_word[15:0];
        byte_en    = 4'b0000;
        write_word = 32'h0;
        load_data  = 32'h0;
        err        = 1'b0;
        if (is_store) begin
            unique case (funct3)
                F3_B: begin
                    byte_en    = 4'b0001 << addr;
                    write_word = 32'(write_data[7:0]) << sh;
                end
                F3_H: begin
                    err        = addr[0];
                    byte_en    = addr[1] ? 4'b1100 : 4'b0011;
                    write_word = addr[1] ? {write_data[15:0], 16'h0}
                                         : {16'h0, write_data[15:0]};
                end
                F3_W: begin
                    err        = |addr;
                    byte_en    = 4'b1111;
                    write_word = write_data;
                end
                default: err = 1'b1;
            endcase
            // A faulting store must leave the array untouched.
            if (err) byte_en = 4'b0000;
        end else begin
            unique case (funct3)
                F3_B:  load_data = {{24{sel_byte[7]}}, sel_byte};
                F3_BU: load_data = {24'h0, sel_byte};
                F3_H: begin
                    err       = addr[0];
                    load_data = {{16{sel_half[15]}}, sel_half};
                end
                F3_HU: begin
                    err       = addr[0];
                    load_data = {16'h0, sel_half};
                end
                F3_W: begin
                    err       = |addr;
                    load_data = read_word;
                end
                default: err = 1'b1;
            endcase
            if (err) load_data = 32'h0;
        end
    end

endmodule

// File: rtl/data_memory_ws.sv
// Data memory with RV32I sub-word access and WAIT_STATES-cycle latency.
// Ports: clk, rst_n (sync, active-low), bus (slave side of the load/store bus).
module data_memory_ws
    import data_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 1
) (
    input logic             clk,
    input logic             rst_n,
    data_memory_ws_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    logic [31:0] mem [DEPTH];

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             accept, exec;

    logic        r_rd, r_wr;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wdata;

    logic        eff_rd, eff_wr;
    logic [2:0]  eff_f3;
    logic [31:0] eff_addr, eff_wdata;
    logic        is_store, is_load;
    logic [ADDR_WIDTH-1:0] word_idx;

    logic [3:0]  byte_en;
    logic [31:0] write_word, load_data;
    logic        acc_err;

    logic [31:0] rdata_q;
    logic        ready_q, err_q;
    logic        unused_addr;

    // In IDLE the live inputs drive the datapath so a zero-wait access
    // can execute on its accepting edge; later the captured copy is used.
    always_comb begin
        if (state == IDLE) begin
            eff_rd    = bus.MemRead;
            eff_wr    = bus.MemWrite;
            eff_f3    = bus.funct3;
            eff_addr  = bus.Mem_Addr;
            eff_wdata = bus.Write_Data;
        end else begin
            eff_rd    = r_rd;
            eff_wr    = r_wr;
            eff_f3    = r_f3;
            eff_addr  = r_addr;
            eff_wdata = r_wdata;
        end
    end

    assign is_store    = eff_wr;
    assign is_load     = eff_rd & ~eff_wr;
    assign word_idx    = eff_addr[ADDR_WIDTH+1:2];
    assign unused_addr = ^{eff_addr[31:ADDR_WIDTH+2]};

    load_store_align u_align (
        .is_store   (is_store),
        .funct3     (eff_f3),
        .addr       (eff_addr[1:0]),
        .write_data (eff_wdata),
        .read_word  (mem[word_idx]),
        .byte_en    (byte_en),
        .write_word (write_word),
        .load_data  (load_data),
        .err        (acc_err)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        exec     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.MemRead | bus.MemWrite) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        exec     = 1'b1;
                        state_nx = DONE;
                    end else begin
                        cnt_nx   = CNT_LOAD;
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    exec     = 1'b1;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_f3    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            ready_q <= exec;
            err_q   <= exec & acc_err;
            if (accept) begin
                r_rd    <= bus.MemRead;
                r_wr    <= bus.MemWrite;
                r_f3    <= bus.funct3;
                r_addr  <= bus.Mem_Addr;
                r_wdata <= bus.Write_Data;
            end
            if (exec && is_load) rdata_q <= load_data;
        end
    end

    // Array is not reset; rst_n gating drops any access cut short by reset.
    always_ff @(posedge clk) begin
        if (rst_n && exec && is_store) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[word_idx][8*i +: 8] <= write_word[8*i +: 8];
            end
        end
    end

    assign bus.Read_Data = rdata_q;
    assign bus.Mem_Ready = ready_q;
    assign bus.Mem_Err   = err_q;

endmodule

// File: tb/tb_data_memory_ws.sv
// Self-checking bench for data_memory_ws: three instances (1/3/0 wait
// states) checked against a byte-array reference model.
module tb_data_memory_ws;

    logic clk;
    logic        rst_n [3];
    logic        rd    [3];
    logic        wr    [3];
    logic [2:0]  f3    [3];
    logic [31:0] ad    [3];
    logic [31:0] wd    [3];
    logic [31:0] rdata [3];
    logic        rdy   [3];
    logic        err   [3];

    int ws_of [3] = '{1, 3, 0};
    int aw_of [3] = '{8, 8, 4};

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  mb   [3][1024];
    logic [31:0] m_rd [3];

    data_memory_ws_if if0 ();
    data_memory_ws_if if1 ();
    data_memory_ws_if if2 ();

    assign if0.MemRead = rd[0];  assign if0.MemWrite = wr[0];
    assign if0.funct3  = f3[0];  assign if0.Mem_Addr = ad[0];
    assign if0.Write_Data = wd[0];
    assign rdata[0] = if0.Read_Data;
    assign rdy[0]   = if0.Mem_Ready;
    assign err[0]   = if0.Mem_Err;

    assign if1.MemRead = rd[1];  assign if1.MemWrite = wr[1];
    assign if1.funct3  = f3[1];  assign if1.Mem_Addr = ad[1];
    assign if1.Write_Data = wd[1];
    assign rdata[1] = if1.Read_Data;
    assign rdy[1]   = if1.Mem_Ready;
    assign err[1]   = if1.Mem_Err;

    assign if2.MemRead = rd[2];  assign if2.MemWrite = wr[2];
    assign if2.funct3  = f3[2];  assign if2.Mem_Addr = ad[2];
    assign if2.Write_Data = wd[2];
    assign rdata[2] = if2.Read_Data;
    assign rdy[2]   = if2.Mem_Ready;
    assign err[2]   = if2.Mem_Err;

    data_memory_ws #(.ADDR_WIDTH(8), .WAIT_STATES(1)) u0 (
        .clk(clk), .rst_n(rst_n[0]), .bus(if0.slave));
    data_memory_ws #(.ADDR_WIDTH(8), .WAIT_STATES(3)) u1 (
        .clk(clk), .rst_n(rst_n[1]), .bus(if1.slave));
    data_memory_ws #(.ADDR_WIDTH(4), .WAIT_STATES(0)) u2 (
        .clk(clk), .rst_n(rst_n[2]), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: memory as a flat byte array, little-endian assembly.
    task automatic ref_op(input int d, input bit st, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] wdv,
                          output logic [31:0] rv, output bit e);
        int nbytes, base, sz;
        logic [31:0] v;
        nbytes = 4 << aw_of[d];
        base   = int'(a % nbytes);
        sz     = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        if (st) e = !(f == 3'd0 || f == 3'd1 || f == 3'd2);
        else    e = (f == 3'd3 || f == 3'd6 || f == 3'd7);
        if ((a % sz) != 0) e = 1'b1;
        v = 32'h0;
        if (!e) begin
            for (int i = 0; i < sz; i++) begin
                if (st) mb[d][base+i] = 8'(wdv >> (8*i));
                else    v = v | (32'(mb[d][base+i]) << (8*i));
            end
            if (!st && !f[2] && sz < 4 && v[8*sz-1])
                v = v | (32'hFFFF_FFFF << (8*sz));
        end
        if (!st) m_rd[d] = e ? 32'h0 : v;
        rv = m_rd[d];
    endtask

    task automatic access(input int d, input bit st, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] wdv,
                          input string tag);
        logic [31:0] exp_rd;
        bit exp_e;
        int k;
        ref_op(d, st, f, a, wdv, exp_rd, exp_e);
        @(negedge clk);
        rd[d] = !st; wr[d] = st; f3[d] = f; ad[d] = a; wd[d] = wdv;
        @(posedge clk); #1;
        rd[d] = 1'b0; wr[d] = 1'b0;
        f3[d] = 3'($urandom); ad[d] = $urandom; wd[d] = $urandom;
        k = 0;
        while (!rdy[d] && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_lat"}, 32'(k), 32'(ws_of[d]));
        check({tag, "_err"}, 32'(err[d]), 32'(exp_e));
        check({tag, "_rdata"}, rdata[d], exp_rd);
        @(posedge clk); #1;
        check({tag, "_rdy_drop"}, 32'({rdy[d], err[d]}), 32'h0);
    endtask

    logic [31:0] dummy;
    bit          dummy_e;
    bit          seen;

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0;
            f3[d] = '0; ad[d] = '0; wd[d] = '0; m_rd[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("reset_rdata", rdata[d], 32'h0);
            check("reset_rdy", 32'(rdy[d]), 32'h0);
            check("reset_err", 32'(err[d]), 32'h0);
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

        // Word access and sub-word loads, one wait state.
        access(0, 1, 3'b010, 32'h0, 32'hAABBCCDD, "sw0");
        access(0, 0, 3'b010, 32'h0, 32'h0, "lw0");
        check("lw0_const", rdata[0], 32'hAABBCCDD);
        access(0, 0, 3'b000, 32'h3, 32'h0, "lb3");
        check("lb3_const", rdata[0], 32'hFFFFFFAA);
        access(0, 0, 3'b100, 32'h3, 32'h0, "lbu3");
        check("lbu3_const", rdata[0], 32'h000000AA);
        access(0, 0, 3'b001, 32'h2, 32'h0, "lh2");
        check("lh2_const", rdata[0], 32'hFFFFAABB);
        access(0, 0, 3'b101, 32'h0, 32'h0, "lhu0");
        check("lhu0_const", rdata[0], 32'h0000CCDD);
        access(0, 1, 3'b000, 32'h1, 32'hFFFFFF11, "sb1");
        access(0, 1, 3'b001, 32'h2, 32'hFFFF2233, "sh2");
        access(0, 0, 3'b010, 32'h0, 32'h0, "lw_merge");
        check("lw_merge_const", rdata[0], 32'h223311DD);

        // Error cases leave the array alone.
        access(0, 1, 3'b010, 32'h4, 32'h01020304, "sw4");
        access(0, 1, 3'b010, 32'h6, 32'h12345678, "sw6_mis");
        access(0, 0, 3'b010, 32'h4, 32'h0, "lw4");
        check("lw4_const", rdata[0], 32'h01020304);
        access(0, 0, 3'b001, 32'h1, 32'h0, "lh1_mis");
        check("lh1_const", rdata[0], 32'h0);
        access(0, 1, 3'b100, 32'h0, 32'h99999999, "st_bad_f3");
        access(0, 0, 3'b011, 32'h0, 32'h0, "ld_bad_f3");
        access(0, 0, 3'b010, 32'h0, 32'h0, "lw_after_bad");
        check("lw_after_bad_const", rdata[0], 32'h223311DD);

        // Random traffic over a pre-initialised window, with aliasing.
        for (int i = 0; i < 16; i++)
            access(0, 1, 3'b010, 32'(i * 4), $urandom, "init");
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 3)) << 10);
            access(0, bit'($urandom_range(0, 1)), 3'($urandom), a,
                   $urandom, "rnd");
        end

        // Reset in the middle of a three-wait-state store.
        access(1, 1, 3'b010, 32'h8, 32'h99887766, "ws3_sw8");
        access(1, 0, 3'b010, 32'h8, 32'h0, "ws3_lw8");
        @(negedge clk);
        wr[1] = 1'b1; f3[1] = 3'b010; ad[1] = 32'h8; wd[1] = 32'h55;
        @(posedge clk); #1;
        wr[1] = 1'b0;
        check("mid_rst_rdy_accept", 32'(rdy[1]), 32'h0);
        @(negedge clk);
        rst_n[1] = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_rdata", rdata[1], 32'h0);
        check("mid_rst_rdy", 32'(rdy[1]), 32'h0);
        check("mid_rst_err", 32'(err[1]), 32'h0);
        m_rd[1] = 32'h0;
        @(negedge clk);
        rst_n[1] = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rdy[1]) seen = 1'b1;
        end
        check("mid_rst_no_rdy", 32'(seen), 32'h0);
        access(1, 0, 3'b010, 32'h8, 32'h0, "ws3_lw8_after");
        check("ws3_lw8_const", rdata[1], 32'h99887766);

        // Zero wait states, 16-word array: wrap and held request.
        access(2, 1, 3'b010, 32'h40, 32'hCAFEF00D, "ws0_sw40");
        access(2, 0, 3'b010, 32'h0, 32'h0, "ws0_lw0");
        check("ws0_lw0_const", rdata[2], 32'hCAFEF00D);
        ref_op(2, 0, 3'b010, 32'h0, 32'h0, dummy, dummy_e);
        @(negedge clk);
        rd[2] = 1'b1; f3[2] = 3'b010; ad[2] = 32'h0;
        @(posedge clk); #1;
        check("hold_rdy0", 32'(rdy[2]), 32'h1);
        check("hold_rdata", rdata[2], dummy);
        @(posedge clk); #1;
        check("hold_rdy1_done_ignored", 32'(rdy[2]), 32'h0);
        @(posedge clk); #1;
        check("hold_rdy2_reaccept", 32'(rdy[2]), 32'h1);
        rd[2] = 1'b0;
        @(posedge clk); #1;
        check("hold_rdy3", 32'(rdy[2]), 32'h0);
        access(2, 0, 3'b101, 32'h3, 32'h0, "ws0_lhu_mis");
        access(2, 0, 3'b000, 32'h43, 32'h0, "ws0_lb_wrap");
        check("ws0_lb_wrap_const", rdata[2], 32'hFFFFFFCA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
